// File: rtl/jtcop_gfx_arb.sv
`default_nettype none
// jtcop_gfx_arb: shares one SDRAM read port among four graphics ROM requesters,
// with a one-entry cache per requester and round-robin fetching of misses.
module jtcop_gfx_arb #(
  parameter logic [21:0] OFFSET0 = 22'h000000,
  parameter logic [21:0] OFFSET1 = 22'h040000,
  parameter logic [21:0] OFFSET2 = 22'h080000,
  parameter logic [21:0] OFFSET3 = 22'h0C0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [3:0]   rom_cs,
  input  logic [71:0]  rom_addr,
  output logic [127:0] rom_data,
  output logic [3:0]   rom_ok,
  output logic         sdram_req,
  output logic [21:0]  sdram_addr,
  input  logic         sdram_ack,
  input  logic         sdram_dst,
  input  logic [31:0]  sdram_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]  state, owner, ptr;
  logic [17:0] lat_addr;
  logic        flush_pend;
  logic [17:0] tag  [4];
  logic [31:0] data [4];
  logic [3:0]  valid;

  logic [17:0] addr   [4];
  logic [21:0] offset [4];
  logic [3:0]  hit, pend;
  logic        busy, fill, gnt_found;
  logic [1:0]  gnt, idx;

  assign busy = (state != IDLE);
  // Data may land in the same cycle the request is accepted.
  assign fill = sdram_dst && ((state == WAIT) || (state == REQ && sdram_ack));

  always_comb begin
    offset[0] = OFFSET0;
    offset[1] = OFFSET1;
    offset[2] = OFFSET2;
    offset[3] = OFFSET3;
    for (int i = 0; i < 4; i++) begin
      addr[i]            = rom_addr[18*i +: 18];
      hit[i]             = valid[i] && (tag[i] == addr[i]);
      pend[i]            = rom_cs[i] && !hit[i] && !(busy && owner == i[1:0]);
      rom_ok[i]          = rom_cs[i] && hit[i];
      rom_data[32*i +: 32] = data[i];
    end
  end

  // Round-robin search starting just after the last served requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt       = ptr;
    idx       = ptr;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + k[1:0];
      if (!gnt_found && pend[idx]) begin
        gnt_found = 1'b1;
        gnt       = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 2'd0;
      ptr        <= 2'd3;
      lat_addr   <= 18'd0;
      flush_pend <= 1'b0;
      sdram_req  <= 1'b0;
      sdram_addr <= 22'd0;
      valid      <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        tag[i]  <= 18'd0;
        data[i] <= 32'd0;
      end
    end else begin
      if (fill) begin
        data[owner] <= sdram_data;
        tag[owner]  <= lat_addr;
        ptr         <= owner;
      end

      if (flush)
        valid <= 4'd0;
      else if (fill && !flush_pend)
        valid[owner] <= 1'b1;

      if (fill)
        flush_pend <= 1'b0;
      else if (flush && busy)
        flush_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (gnt_found) begin
            owner      <= gnt;
            lat_addr   <= addr[gnt];
            sdram_addr <= offset[gnt] + {4'd0, addr[gnt]};
            sdram_req  <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            state     <= sdram_dst ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (sdram_dst)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
